// File: rtl/rs_pkg.sv
// Shared types for the ALU reservation station.
//   CMD_W    : width of the decoded command bits carried through the station
//   DATA_W   : operand width
//   ROB_SIZE : ROB depth; TAG_W is the ROB tag width derived from it
//   rs_src_t : one source operand (value, present bit, producer tag)
//   rs_entry_t : one station entry (busy, command, tag, three sources)
package rs_pkg;

  localparam int CMD_W    = 10;
  localparam int DATA_W   = 64;
  localparam int ROB_SIZE = 8;
  localparam int TAG_W    = $clog2(ROB_SIZE + 1);
  localparam int NSRC     = 3;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              valid;
    rob_tag_t          tag;
  } rs_src_t;

  typedef struct packed {
    logic                 busy;
    logic [CMD_W-1:0]     commands;
    rob_tag_t             tag;
    rs_src_t [NSRC-1:0]   src;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: holds a dispatched instruction, snoops the
// CDB to fill missing operands and reports when all operands are present.
//   clk, rst     : clock, asynchronous active-high reset (clears busy only)
//   flush        : clear the entry at the next edge (wins over everything)
//   wr, wr_data  : load a newly dispatched instruction (entry must be free)
//   issue        : entry is consumed by the execute stage at this edge
//   cdb_*        : common data bus broadcast
//   busy, ready  : occupancy and all-operands-present, from registered state
//   commands, tag, vals : stored instruction presented for issue
module rs_entry
  import rs_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr,
  input  rs_entry_t                   wr_data,
  input  logic                        issue,
  input  logic                        cdb_valid,
  input  rob_tag_t                    cdb_tag,
  input  logic [DATA_W-1:0]           cdb_val,
  output logic                        busy,
  output logic                        ready,
  output logic [CMD_W-1:0]            commands,
  output rob_tag_t                    tag,
  output logic [NSRC-1:0][DATA_W-1:0] vals
);

  rs_entry_t q;
  rs_entry_t nxt;

  // A missing operand whose producer tag is on the CDB takes the broadcast value.
  function automatic rs_src_t capture(input rs_src_t s, input logic cv,
                                      input rob_tag_t ct, input logic [DATA_W-1:0] cval);
    rs_src_t r;
    r = s;
    if (!s.valid && cv && (s.tag == ct)) begin
      r.val   = cval;
      r.valid = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    nxt = q;
    if (flush) begin
      nxt.busy = 1'b0;
    end else if (wr) begin
      // Dispatch write also applies the same-cycle CDB bypass.
      nxt = wr_data;
      for (int j = 0; j < NSRC; j++)
        nxt.src[j] = capture(wr_data.src[j], cdb_valid, cdb_tag, cdb_val);
    end else if (q.busy) begin
      for (int j = 0; j < NSRC; j++)
        nxt.src[j] = capture(q.src[j], cdb_valid, cdb_tag, cdb_val);
      if (issue) nxt.busy = 1'b0;
    end
  end

  // Only busy is reset; payload fields are don't-care while the entry is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q.busy <= 1'b0;
    else     q      <= nxt;
  end

  assign busy     = q.busy;
  assign ready    = q.busy & q.src[0].valid & q.src[1].valid & q.src[2].valid;
  assign commands = q.commands;
  assign tag      = q.tag;
  always_comb begin
    for (int j = 0; j < NSRC; j++) vals[j] = q.src[j].val;
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU instructions until their
// operands arrive (directly or via the CDB) and issues the lowest-index ready
// entry to the execute stage, honouring its stall.
//   clk_i, reset_i, flush_i        : clock, async active-high reset, sync flush
//   dispatch*/src*                 : dispatch request and its operands
//   full_o, count_o                : occupancy (from registered state)
//   cdbValid_i/cdbTag_i/cdbVal_i   : CDB broadcast for wakeup
//   reservationStation*_o, RSVal3_o, readyRS_o : issue port (zero when idle)
//   stallRS_i                      : execute stage cannot accept this cycle
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int RSsize     = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          dispatchValid_i,
  input  logic [9:0]                    dispatchCommands_i,
  input  logic [ROBsizeLog-1:0]         dispatchTag_i,
  input  logic [63:0]                   src1Val_i,
  input  logic [63:0]                   src2Val_i,
  input  logic [63:0]                   src3Val_i,
  input  logic                          src1Valid_i,
  input  logic                          src2Valid_i,
  input  logic                          src3Valid_i,
  input  logic [ROBsizeLog-1:0]         src1Tag_i,
  input  logic [ROBsizeLog-1:0]         src2Tag_i,
  input  logic [ROBsizeLog-1:0]         src3Tag_i,
  output logic                          full_o,
  output logic [$clog2(RSsize+1)-1:0]   count_o,
  input  logic                          cdbValid_i,
  input  logic [ROBsizeLog-1:0]         cdbTag_i,
  input  logic [63:0]                   cdbVal_i,
  output logic [63:0]                   reservationStationVal1_o,
  output logic [63:0]                   reservationStationVal2_o,
  output logic [63:0]                   RSVal3_o,
  output logic [9:0]                    reservationStationCommands_o,
  output logic [ROBsizeLog-1:0]         reservationStationTag_o,
  output logic                          readyRS_o,
  input  logic                          stallRS_i
);

  localparam int IDX_W = (RSsize > 1) ? $clog2(RSsize) : 1;
  localparam int CNT_W = $clog2(RSsize + 1);

  logic [RSsize-1:0]               busy;
  logic [RSsize-1:0]               ready;
  logic [RSsize-1:0]               wr;
  logic [RSsize-1:0]               issue;
  logic [CMD_W-1:0]                ent_cmd [RSsize];
  rob_tag_t                        ent_tag [RSsize];
  logic [NSRC-1:0][DATA_W-1:0]     ent_val [RSsize];

  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             ready_any;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic             fire;
  rs_entry_t        wr_data;
  logic [CNT_W-1:0] count_q;

  // Lowest-index free slot for dispatch.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < RSsize; i++) begin
      if (!busy[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
    end
  end

  // Lowest-index ready slot for issue.
  always_comb begin
    ready_any = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RSsize; i++) begin
      if (ready[i] && !ready_any) begin
        ready_any = 1'b1;
        sel_idx   = i[IDX_W-1:0];
      end
    end
  end

  assign accept = dispatchValid_i & free_any & ~flush_i;
  assign fire   = ready_any & ~stallRS_i;

  always_comb begin
    wr_data            = '0;
    wr_data.busy       = 1'b1;
    wr_data.commands   = dispatchCommands_i;
    wr_data.tag        = dispatchTag_i;
    wr_data.src[0].val = src1Val_i;
    wr_data.src[0].valid = src1Valid_i;
    wr_data.src[0].tag = src1Tag_i;
    wr_data.src[1].val = src2Val_i;
    wr_data.src[1].valid = src2Valid_i;
    wr_data.src[1].tag = src2Tag_i;
    wr_data.src[2].val = src3Val_i;
    wr_data.src[2].valid = src3Valid_i;
    wr_data.src[2].tag = src3Tag_i;
  end

  for (genvar g = 0; g < RSsize; g++) begin : g_entry
    assign wr[g]    = accept & (free_idx == IDX_W'(g));
    assign issue[g] = fire & (sel_idx == IDX_W'(g));

    rs_entry u_entry (
      .clk       (clk_i),
      .rst       (reset_i),
      .flush     (flush_i),
      .wr        (wr[g]),
      .wr_data   (wr_data),
      .issue     (issue[g]),
      .cdb_valid (cdbValid_i),
      .cdb_tag   (cdbTag_i),
      .cdb_val   (cdbVal_i),
      .busy      (busy[g]),
      .ready     (ready[g]),
      .commands  (ent_cmd[g]),
      .tag       (ent_tag[g]),
      .vals      (ent_val[g])
    );
  end

  // Issue mux: outputs are forced to zero when nothing is issuable.
  always_comb begin
    readyRS_o                    = ready_any;
    reservationStationVal1_o     = '0;
    reservationStationVal2_o     = '0;
    RSVal3_o                     = '0;
    reservationStationCommands_o = '0;
    reservationStationTag_o      = '0;
    if (ready_any) begin
      reservationStationVal1_o     = ent_val[sel_idx][0];
      reservationStationVal2_o     = ent_val[sel_idx][1];
      RSVal3_o                     = ent_val[sel_idx][2];
      reservationStationCommands_o = ent_cmd[sel_idx];
      reservationStationTag_o      = ent_tag[sel_idx];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      count_q <= '0;
    else if (flush_i) count_q <= '0;
    else              count_q <= count_q - CNT_W'(fire) + CNT_W'(accept);
  end

  assign count_o = count_q;
  assign full_o  = &busy;

endmodule
